// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage. Drives a word-wide data memory and
// handles RV32 byte/half/word loads and stores. Sub-word loads extract and
// extend a lane from a full word read; sub-word stores read the word, merge
// the new lane(s) and write the whole word back.
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    output logic [31:0] LOAD_DATA,
    output logic        BUSY,
    output logic        ACCESS_FAULT,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [31:0] DM_ADDRESS,
    output logic [31:0] DM_WRITEDATA,
    input  logic [31:0] DM_READDATA
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Index of the last RD_WAIT cycle; the word is captured on that edge.
    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] sdata_q, sdata_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic [31:0] dm_address_q, dm_address_d;
    logic [31:0] dm_writedata_q, dm_writedata_d;

    logic        req_fault;
    logic [31:0] extracted;
    logic [31:0] merged;

    // Classify the incoming request as misaligned or illegal.
    always_comb begin
        req_fault = 1'b0;
        if (MEM_READ && MEM_WRITE) begin
            req_fault = 1'b1;
        end else if (MEM_READ) begin
            case (FUNCT3)
                3'b000, 3'b100: req_fault = 1'b0;
                3'b001, 3'b101: req_fault = ADDR[0];
                3'b010:         req_fault = (ADDR[1:0] != 2'b00);
                default:        req_fault = 1'b1;
            endcase
        end else if (MEM_WRITE) begin
            case (FUNCT3)
                3'b000:  req_fault = 1'b0;
                3'b001:  req_fault = ADDR[0];
                3'b010:  req_fault = (ADDR[1:0] != 2'b00);
                default: req_fault = 1'b1;
            endcase
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        case (addr_lo_q)
            2'b00:   lane_byte = DM_READDATA[7:0];
            2'b01:   lane_byte = DM_READDATA[15:8];
            2'b10:   lane_byte = DM_READDATA[23:16];
            default: lane_byte = DM_READDATA[31:24];
        endcase
        lane_half = addr_lo_q[1] ? DM_READDATA[31:16] : DM_READDATA[15:0];

        case (funct3_q)
            3'b000:  extracted = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  extracted = {24'h0, lane_byte};
            3'b001:  extracted = {{16{lane_half[15]}}, lane_half};
            3'b101:  extracted = {16'h0, lane_half};
            default: extracted = DM_READDATA;
        endcase

        merged = DM_READDATA;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_lo_q)
                2'b00:   merged[7:0]   = sdata_q[7:0];
                2'b01:   merged[15:8]  = sdata_q[7:0];
                2'b10:   merged[23:16] = sdata_q[7:0];
                default: merged[31:24] = sdata_q[7:0];
            endcase
        end else begin
            if (addr_lo_q[1]) begin
                merged[31:16] = sdata_q;
            end else begin
                merged[15:0] = sdata_q;
            end
        end
    end

    // Next-state and next-register logic for the access sequencer.
    always_comb begin
        state_d        = state_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
        sdata_d        = sdata_q;
        is_store_d     = is_store_q;
        cnt_d          = cnt_q;
        load_data_d    = load_data_q;
        fault_d        = fault_q;
        dm_address_d   = dm_address_q;
        dm_writedata_d = dm_writedata_q;

        case (state_q)
            IDLE: begin
                if (MEM_READ || MEM_WRITE) begin
                    funct3_d   = FUNCT3;
                    addr_lo_d  = ADDR[1:0];
                    sdata_d    = STORE_DATA[15:0];
                    is_store_d = MEM_WRITE;
                    cnt_d      = 3'd0;
                    if (req_fault) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        fault_d      = 1'b0;
                        dm_address_d = {ADDR[31:2], 2'b00};
                        if (MEM_WRITE && (FUNCT3 == 3'b010)) begin
                            // Full-word store needs no read; write directly.
                            dm_writedata_d = STORE_DATA;
                            state_d        = WR_REQ;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: begin
                cnt_d   = 3'd0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    if (is_store_q) begin
                        dm_writedata_d = merged;
                        state_d        = WR_REQ;
                    end else begin
                        load_data_d = extracted;
                        state_d     = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR_REQ: begin
                state_d = DONE;
            end
            DONE: begin
                // The pipeline advances on this edge; the held request is ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request-latch registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= IDLE;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 2'd0;
            sdata_q        <= 16'd0;
            is_store_q     <= 1'b0;
            cnt_q          <= 3'd0;
            load_data_q    <= 32'd0;
            fault_q        <= 1'b0;
            dm_address_q   <= 32'd0;
            dm_writedata_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            sdata_q        <= sdata_d;
            is_store_q     <= is_store_d;
            cnt_q          <= cnt_d;
            load_data_q    <= load_data_d;
            fault_q        <= fault_d;
            dm_address_q   <= dm_address_d;
            dm_writedata_q <= dm_writedata_d;
        end
    end

    // BUSY rises combinationally with a new request so the pipeline stalls at once.
    assign BUSY = ((state_q == IDLE) && (MEM_READ || MEM_WRITE)) ||
                  (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);

    assign DM_READ      = (state_q == RD_REQ);
    assign DM_WRITE     = (state_q == WR_REQ);
    assign ACCESS_FAULT = (state_q == DONE) && fault_q;
    assign LOAD_DATA    = load_data_q;
    assign DM_ADDRESS   = dm_address_q;
    assign DM_WRITEDATA = dm_writedata_q;

endmodule
